testing_step_arbiter: RTL
=========================

# testing_step_arbiter

Two-port round-robin arbiter that shares one `testing` state machine (S/T core, K/L Mealy outputs, N sequential output) between two requesters. Each accepted command is one clock step of the shared machine: the arbiter registers the requester's {A,B,C} command, drives it for exactly one cycle, captures K/L, and returns the post-step {S,T,N,K,L} tagged with the requester id. An optional lock gives one requester a bounded burst of back-to-back steps with no interleaving.

## Interface
- `MAX_BURST`, default 4: maximum handshakes in one locked burst, counting the first. Legal range 1..15.

- `clk`  in  1  single clock, rising edge
- `n_reset`  in  1  asynchronous, active-low reset
- `req0_valid`, `req1_valid`  in  1  requester has a command
- `req0_cmd`, `req1_cmd`  in  3  {A,B,C}
- `req0_lock`, `req1_lock`  in  1  request ownership after this handshake
- `req0_ready`, `req1_ready`  out  1  grant; transfer when valid & ready
- `rsp_valid`  out  1  response strobe, one cycle, no backpressure
- `rsp_id`  out  1  requester the response belongs to
- `rsp_data`  out  5  {S,T,N,K,L}
- `fsm_a`, `fsm_b`, `fsm_c`  out  1  inputs to the shared machine
- `fsm_s`, `fsm_t`, `fsm_n`, `fsm_k`, `fsm_l`  in  1  outputs of the shared machine

## Operation
- Arbiter states: IDLE, OWN0, OWN1. Round-robin pointer `last`, which records the last granted id.
- IDLE: `reqX_ready` = `reqX_valid` & (other not valid | `last` != X). This is combinational from the valids and registered state only.
- OWNx: only `reqx_ready` may be high (= `reqx_valid`). The other port's ready is 0.
- On a handshake by X:
  - `last` <= X.
  - The command register loads `reqX_cmd`, with the id.
  - `burst` increments.
- Transitions:
  - IDLE -> OWNx: handshake with `reqx_lock`=1 and `MAX_BURST` > 1. `burst` <= 1.
  - OWNx -> OWNx: handshake with lock=1 and `burst`+1 < `MAX_BURST`.
  - OWNx -> IDLE on any of:
    - handshake with lock=0;
    - handshake that makes `burst` reach `MAX_BURST`, regardless of lock;
    - any cycle with `reqx_valid`=0 (no handshake that cycle).
  - Every entry to IDLE clears `burst`.
- Step stage:
  - Cycle after a handshake: `fsm_a/b/c` = registered cmd.
  - Any cycle with no registered command: `fsm_a/b/c` = 0 (idle step). The shared machine still advances on idle steps; requesters needing contiguous steps must use lock.
- Capture: at the end of a step cycle, K and L are registered together with the id and a pending flag.
- Response: in the next cycle, `rsp_valid`=1 and `rsp_data` = {`fsm_s`, `fsm_t`, `fsm_n`, K_q, L_q}, so S/T/N are post-step values. `rsp_id` = captured id.
- `rsp_valid`=0 otherwise. `rsp_data` and `rsp_id` hold their last values when not valid.

## Timing
- Reset values:
  - state IDLE, `last`=1 (req0 wins the first tie), `burst`=0;
  - command register empty, `fsm_a/b/c`=0;
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0;
  - `req0_ready` and `req1_ready` follow the IDLE equation.
- Latency: handshake in cycle n -> step in n+1 -> response in n+2. Throughput is one command per cycle.
- Simultaneous valids in IDLE: grant the requester that is not `last`. The loser's ready stays 0. The loser must hold valid and cmd until its handshake.
- Burst end at `MAX_BURST`: the next IDLE cycle's tie goes to the other requester, because `last` = owner.
- Reset asserted mid-operation: registered commands and pending responses are discarded. No `rsp_valid` is issued for them. Outputs take their reset values asynchronously.

## Test plan
- Reset, then req0 sends a locked burst with lock=1 on the first two and lock=0 on the third:
  - cmds {A,B,C} = 100, 011, 001 back-to-back;
  - required: `rsp_valid` in cycles n+2..n+4 with id 0;
  - `rsp_data` = 01000, 11010, 00101.
- Both valid in IDLE right after reset, lock=0: req0 is granted first, req1 next cycle, then alternating while both stay valid. Responses carry ids 0,1,0,1, each exactly 2 cycles after its handshake.
- `MAX_BURST`=4, req0 holds lock=1 and valid, req1 valid: req0 gets exactly 4 consecutive grants, then req1 is granted. `req1_ready`=0 throughout the burst.
- In OWN0, drop `req0_valid` for one cycle with req1 waiting: the state returns to IDLE and req1 is granted on the next cycle.
- No requests for 3 cycles from state 01: `fsm_a/b/c`=000, `rsp_valid`=0, and the shared machine walks 01 -> 11 -> 00 -> 00.
- Assert `n_reset` in the cycle after a handshake: no response is produced. After release, `rsp_valid`=0 and `fsm_a/b/c`=000.

Source files
------------

// File: rtl/testing_step_arbiter.sv
// testing_step_arbiter
// ---------------------------------------------------------------------------
// Purpose: shares one external `testing` state machine between two
// requesters. The machine has an S/T core, K/L Mealy outputs and a sequential
// N output. Each accepted command becomes exactly one clock step of that
// machine. The step's K/L are captured, and one cycle later the post-step
// {S,T,N,K,L} is returned, tagged with the requester id. Arbitration is
// round-robin. A requester can lock the machine for a bounded burst of
// back-to-back steps.
//
// Ports:
//   clk                     rising-edge clock
//   n_reset                 asynchronous active-low reset
//   req0_valid/req1_valid   requester has a command
//   req0_cmd/req1_cmd       {A,B,C} command
//   req0_lock/req1_lock     keep ownership after this handshake
//   req0_ready/req1_ready   grant (transfer on valid & ready)
//   rsp_valid               one-cycle response strobe, no backpressure
//   rsp_id                  requester the response belongs to
//   rsp_data                {S,T,N,K,L} after the step
//   fsm_a/fsm_b/fsm_c       step inputs driven to the shared machine
//   fsm_s/fsm_t/fsm_n       state / sequential output of the shared machine
//   fsm_k/fsm_l             Mealy outputs of the shared machine
// ---------------------------------------------------------------------------
module testing_step_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       req0_valid,
  input  logic [2:0] req0_cmd,
  input  logic       req0_lock,
  input  logic       req1_valid,
  input  logic [2:0] req1_cmd,
  input  logic       req1_lock,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [4:0] rsp_data,
  output logic       fsm_a,
  output logic       fsm_b,
  output logic       fsm_c,
  input  logic       fsm_s,
  input  logic       fsm_t,
  input  logic       fsm_n,
  input  logic       fsm_k,
  input  logic       fsm_l
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  // A burst of one is just a normal handshake, so locking is only useful
  // when more than one step per burst is allowed.
  localparam bit         LOCK_EN = (MAX_BURST > 1);
  localparam logic [3:0] MAX_B   = 4'(MAX_BURST);

  state_t     state_q;
  logic       last_q;      // id of the most recent grant
  logic [3:0] burst_q;     // handshakes in the current locked burst
  logic [2:0] cmd_q;       // command driven to the machine this cycle
  logic       cmd_vld_q;   // cmd_q holds a real command (not an idle step)
  logic       cmd_id_q;
  logic       pend_q;      // response is due this cycle
  logic       k_q;
  logic       l_q;
  logic       id_q;
  logic [2:0] stn_hold_q;  // last returned S/T/N, held while not valid

  logic       hs0;
  logic       hs1;
  logic       hs;
  logic       hs_id;
  logic       hs_lock;
  logic [2:0] hs_cmd;
  logic [3:0] burst_inc;

  // Grant logic: in IDLE a tie goes to the requester that was not granted
  // last; while owned only the owner can be granted.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = req0_valid & (~req1_valid | last_q);
        req1_ready = req1_valid & (~req0_valid | ~last_q);
      end
      ST_OWN0: req0_ready = req0_valid;
      ST_OWN1: req1_ready = req1_valid;
      default: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
      end
    endcase
  end

  assign hs0       = req0_valid & req0_ready;
  assign hs1       = req1_valid & req1_ready;
  assign hs        = hs0 | hs1;
  assign hs_id     = hs1;
  assign hs_lock   = hs1 ? req1_lock : req0_lock;
  assign hs_cmd    = hs1 ? req1_cmd : req0_cmd;
  assign burst_inc = burst_q + 4'd1;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      burst_q    <= 4'd0;
      cmd_q      <= 3'b000;
      cmd_vld_q  <= 1'b0;
      cmd_id_q   <= 1'b0;
      pend_q     <= 1'b0;
      k_q        <= 1'b0;
      l_q        <= 1'b0;
      id_q       <= 1'b0;
      stn_hold_q <= 3'b000;
    end else begin
      // Command register: a handshake becomes next cycle's step, otherwise
      // the machine gets an idle step (all-zero inputs).
      cmd_q     <= hs ? hs_cmd : 3'b000;
      cmd_vld_q <= hs;
      if (hs) begin
        last_q   <= hs_id;
        cmd_id_q <= hs_id;
      end

      case (state_q)
        ST_IDLE: begin
          if (hs && hs_lock && LOCK_EN) begin
            state_q <= hs_id ? ST_OWN1 : ST_OWN0;
            burst_q <= 4'd1;
          end else begin
            burst_q <= 4'd0;
          end
        end
        ST_OWN0, ST_OWN1: begin
          // While owned, ready == valid, so no handshake means the owner
          // dropped valid and gives up the machine.
          if (hs && hs_lock && (burst_inc < MAX_B)) begin
            burst_q <= burst_inc;
          end else begin
            state_q <= ST_IDLE;
            burst_q <= 4'd0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          burst_q <= 4'd0;
        end
      endcase

      // Capture the Mealy outputs at the end of the step cycle; S/T/N are
      // read live in the response cycle so they reflect the post-step state.
      pend_q <= cmd_vld_q;
      if (cmd_vld_q) begin
        k_q  <= fsm_k;
        l_q  <= fsm_l;
        id_q <= cmd_id_q;
      end
      if (pend_q) begin
        stn_hold_q <= {fsm_s, fsm_t, fsm_n};
      end
    end
  end

  assign fsm_a     = cmd_q[2];
  assign fsm_b     = cmd_q[1];
  assign fsm_c     = cmd_q[0];
  assign rsp_valid = pend_q;
  assign rsp_id    = id_q;
  assign rsp_data  = pend_q ? {fsm_s, fsm_t, fsm_n, k_q, l_q}
                            : {stn_hold_q, k_q, l_q};

endmodule
